// File: rtl/sbox_ti_pkg.sv
// Shared types, constants and GF(2^8) helpers for the S-box inversion scheduler.
// The GF arithmetic uses the AES field polynomial x^8 + x^4 + x^3 + x + 1.
package sbox_ti_pkg;

  localparam int RAND_W   = 28;
  localparam int CORE_LAT = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } sched_state_e;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse, and maps 0 to 0 for free.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] acc;
    acc = 8'h01;
    sq  = a;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

endpackage

// File: rtl/sbox_ti_sched_if.sv
// Request/response bundle between a state producer and the inversion scheduler.
interface sbox_ti_sched_if #(
  parameter int NBYTES = 16
);
  import sbox_ti_pkg::*;

  // start is taken only while idle and only together with r_valid=1. While busy,
  // r_ack=1 every cycle (r_in consumed); r_valid=0 in any busy cycle aborts the run.
  logic                  start;
  logic [8*NBYTES-1:0]   din0;
  logic [8*NBYTES-1:0]   din1;
  logic [RAND_W-1:0]     r_in;
  logic                  r_valid;
  logic                  r_ack;
  logic                  busy;
  logic                  done;
  logic                  err;
  logic [8*NBYTES-1:0]   dout0;
  logic [8*NBYTES-1:0]   dout1;
  logic [8*NBYTES-1:0]   dout2;
  logic [8*NBYTES-1:0]   dout3;

  modport master (
    output start, din0, din1, r_in, r_valid,
    input  r_ack, busy, done, err, dout0, dout1, dout2, dout3
  );

  modport slave (
    input  start, din0, din1, r_in, r_valid,
    output r_ack, busy, done, err, dout0, dout1, dout2, dout3
  );

endinterface

// File: rtl/inversion_TI_opt.sv
// Two-stage shared GF(2^8) inverter: 2 input shares, 4 output shares, 28 random bits.
// Output shares recombine (XOR) to the inverse of the recombined input.
module inversion_TI_opt
  import sbox_ti_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [7:0]        i_a0,
  input  logic [7:0]        i_a1,
  input  logic [RAND_W-1:0] i_rnd,
  output logic [7:0]        o_b0,
  output logic [7:0]        o_b1,
  output logic [7:0]        o_b2,
  output logic [7:0]        o_b3
);

  logic [7:0]        r_s0;
  logic [7:0]        r_s1;
  logic [RAND_W-9:0] r_rnd;
  logic [7:0]        w_inv;
  logic [7:0]        w_m1;
  logic [7:0]        w_m2;
  logic [7:0]        w_m3;

  // Stage 1: refresh both input shares with a common mask, keep the output masks.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s0  <= '0;
      r_s1  <= '0;
      r_rnd <= '0;
    end else begin
      r_s0  <= i_a0 ^ i_rnd[7:0];
      r_s1  <= i_a1 ^ i_rnd[7:0];
      r_rnd <= i_rnd[RAND_W-1:8];
    end
  end

  always_comb begin
    w_m1  = r_rnd[7:0];
    w_m2  = r_rnd[15:8];
    w_m3  = {r_rnd[19:16], r_rnd[19:16]} ^ w_m1 ^ w_m2;
    w_inv = gf_inv(r_s0 ^ r_s1);
  end

  // Stage 2: split the inverse into four shares.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_b0 <= '0;
      o_b1 <= '0;
      o_b2 <= '0;
      o_b3 <= '0;
    end else begin
      o_b0 <= w_inv ^ w_m1 ^ w_m2 ^ w_m3;
      o_b1 <= w_m1;
      o_b2 <= w_m2;
      o_b3 <= w_m3;
    end
  end

endmodule

// File: rtl/sbox_ti_sched.sv
// Byte sequencer feeding one shared inversion core with a whole state, one byte per cycle.
// Build option SBOX_SCHED_GATE_EN zeroes the core data inputs outside issue cycles.
module sbox_ti_sched
  import sbox_ti_pkg::*;
#(
  parameter int NBYTES = 16
) (
  input  logic          CLK,
  input  logic          RST,
  sbox_ti_sched_if.slave bus,
  output sched_state_e  o_dbg_state
);

  localparam int            CW         = 5;
  localparam logic [CW-1:0] LAST       = CW'(NBYTES - 1);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(CORE_LAT - 1);

  sched_state_e r_state;
  sched_state_e w_state_nxt;

  logic [CW-1:0]                r_cnt;
  logic [CW-1:0]                r_drain;
  logic [8*NBYTES-1:0]          r_buf0;
  logic [8*NBYTES-1:0]          r_buf1;
  logic [CORE_LAT-1:0]          r_vpipe;
  logic [CORE_LAT-1:0][CW-1:0]  r_ipipe;
  logic                         r_done;
  logic                         r_err;
  logic [8*NBYTES-1:0]          r_dout0;
  logic [8*NBYTES-1:0]          r_dout1;
  logic [8*NBYTES-1:0]          r_dout2;
  logic [8*NBYTES-1:0]          r_dout3;

  logic       w_busy;
  logic       w_abort;
  logic       w_accept;
  logic       w_issue;
  logic       w_last_issue;
  logic       w_drain_end;
  logic       w_capture;
  logic [7:0] w_sel0;
  logic [7:0] w_sel1;
  logic [7:0] w_core_a0;
  logic [7:0] w_core_a1;
  logic [7:0] w_cb0;
  logic [7:0] w_cb1;
  logic [7:0] w_cb2;
  logic [7:0] w_cb3;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_busy       = (r_state != ST_IDLE);
    w_abort      = w_busy && !bus.r_valid;
    w_accept     = (r_state == ST_IDLE) && bus.start && bus.r_valid;
    w_issue      = (r_state == ST_ISSUE);
    w_last_issue = w_issue && (r_cnt == LAST);
    w_drain_end  = (r_state == ST_DRAIN) && (r_drain == DRAIN_LAST);
    w_capture    = r_vpipe[CORE_LAT-1] && !w_abort;
    unique case (r_state)
      ST_IDLE:  if (w_accept)     w_state_nxt = ST_ISSUE;
      ST_ISSUE: if (w_last_issue) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (w_drain_end)  w_state_nxt = ST_IDLE;
      default:                    w_state_nxt = ST_IDLE;
    endcase
    if (w_abort) w_state_nxt = ST_IDLE;
  end

  // The counter parks on the last driven byte, so the mux below keeps presenting it.
  always_comb begin
    w_sel0 = '0;
    w_sel1 = '0;
    for (int b = 0; b < NBYTES; b++) begin
      if (r_cnt == CW'(b)) begin
        w_sel0 = r_buf0[8*b +: 8];
        w_sel1 = r_buf1[8*b +: 8];
      end
    end
  end

`ifdef SBOX_SCHED_GATE_EN
  assign w_core_a0 = w_issue ? w_sel0 : 8'h00;
  assign w_core_a1 = w_issue ? w_sel1 : 8'h00;
`else
  assign w_core_a0 = w_sel0;
  assign w_core_a1 = w_sel1;
`endif

  inversion_TI_opt u_core (
    .i_clk (CLK),
    .i_rst (RST),
    .i_a0  (w_core_a0),
    .i_a1  (w_core_a1),
    .i_rnd (bus.r_in),
    .o_b0  (w_cb0),
    .o_b1  (w_cb1),
    .o_b2  (w_cb2),
    .o_b3  (w_cb3)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_cnt   <= '0;
      r_drain <= '0;
      r_buf0  <= '0;
      r_buf1  <= '0;
      r_vpipe <= '0;
      r_ipipe <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_buf0 <= bus.din0;
        r_buf1 <= bus.din1;
        r_cnt  <= '0;
        r_err  <= 1'b0;
      end else if (w_issue && !w_last_issue && !w_abort) begin
        r_cnt <= r_cnt + 1'b1;
      end
      r_drain <= (r_state == ST_DRAIN) ? r_drain + 1'b1 : '0;
      r_ipipe <= {r_ipipe[CORE_LAT-2:0], r_cnt};
      if (w_abort) begin
        r_err   <= 1'b1;
        r_vpipe <= '0;
      end else begin
        r_vpipe <= {r_vpipe[CORE_LAT-2:0], w_issue};
      end
      r_done <= w_drain_end && !w_abort;
    end
  end

  // The final capture coincides with the drain-end edge, which also raises done.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_dout0 <= '0;
      r_dout1 <= '0;
      r_dout2 <= '0;
      r_dout3 <= '0;
    end else if (w_capture) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (r_ipipe[CORE_LAT-1] == CW'(b)) begin
          r_dout0[8*b +: 8] <= w_cb0;
          r_dout1[8*b +: 8] <= w_cb1;
          r_dout2[8*b +: 8] <= w_cb2;
          r_dout3[8*b +: 8] <= w_cb3;
        end
      end
    end
  end

  assign bus.busy    = w_busy;
  assign bus.r_ack   = w_busy;
  assign bus.done    = r_done;
  assign bus.err     = r_err;
  assign bus.dout0   = r_dout0;
  assign bus.dout1   = r_dout1;
  assign bus.dout2   = r_dout2;
  assign bus.dout3   = r_dout3;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_sbox_ti_sched.sv
// Directed bench for sbox_ti_sched: a 16-byte and a 1-byte instance share clock and reset.
module tb_sbox_ti_sched;
  import sbox_ti_pkg::*;

  logic CLK = 1'b0;
  logic RST;
  int   tests_run    = 0;
  int   tests_failed = 0;

  sbox_ti_sched_if #(.NBYTES(16)) bus16 ();
  sbox_ti_sched_if #(.NBYTES(1))  bus1 ();
  sched_state_e dbg16;
  sched_state_e dbg1;

  sbox_ti_sched #(.NBYTES(16)) dut16 (.CLK(CLK), .RST(RST), .bus(bus16), .o_dbg_state(dbg16));
  sbox_ti_sched #(.NBYTES(1))  dut1  (.CLK(CLK), .RST(RST), .bus(bus1),  .o_dbg_state(dbg1));

  always #5 CLK = ~CLK;

  initial begin
    bus16.r_in = '0;
    bus1.r_in  = '0;
    forever begin
      @(negedge CLK);
      bus16.r_in = 28'($urandom);
      bus1.r_in  = 28'($urandom);
    end
  end

  // Reference GF(2^8) model: schoolbook product, polynomial reduction, brute-force inverse.
  function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
    for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (15'h11B << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [7:0] m_inv(input logic [7:0] x);
    logic [7:0] y;
    y = 8'h00;
    for (int c = 1; c < 256; c++) if (m_mul(x, 8'(c)) == 8'h01) y = 8'(c);
    return y;
  endfunction

  function automatic logic [127:0] m_inv_state(input logic [127:0] x);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[8*k +: 8] = m_inv(x[8*k +: 8]);
    return r;
  endfunction

  function automatic logic [127:0] recomb16();
    return bus16.dout0 ^ bus16.dout1 ^ bus16.dout2 ^ bus16.dout3;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic wait_done16(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus16.done && n < 40);
  endtask

  task automatic run16(input string tag, input logic [127:0] x, input logic [127:0] mask);
    int n;
    bus16.din0  = x ^ mask;
    bus16.din1  = mask;
    bus16.start = 1'b1;
    tick();
    bus16.start = 1'b0;
    chk({tag, "_busy"}, 128'(bus16.busy), 128'd1);
    chk({tag, "_rack"}, 128'(bus16.r_ack), 128'd1);
    wait_done16(n);
    chk({tag, "_latency"}, 128'(n), 128'd18);
    chk({tag, "_busy_off"}, 128'(bus16.busy), 128'd0);
    chk({tag, "_data"}, recomb16(), m_inv_state(x));
    tick();
    chk({tag, "_done_pulse"}, 128'(bus16.done), 128'd0);
  endtask

  initial begin
    logic [127:0] x;
    logic [127:0] got;
    int n;
    int seen;
    int first;
    int second;

    RST           = 1'b1;
    bus16.start   = 1'b0;
    bus16.r_valid = 1'b1;
    bus16.din0    = '0;
    bus16.din1    = '0;
    bus1.start    = 1'b0;
    bus1.r_valid  = 1'b1;
    bus1.din0     = '0;
    bus1.din1     = '0;

    // Reset state
    repeat (3) @(negedge CLK);
    chk("rst_busy", 128'(bus16.busy), 128'd0);
    chk("rst_done", 128'(bus16.done), 128'd0);
    chk("rst_err", 128'(bus16.err), 128'd0);
    chk("rst_rack", 128'(bus16.r_ack), 128'd0);
    chk("rst_dout", bus16.dout0 | bus16.dout1 | bus16.dout2 | bus16.dout3, 128'd0);
    chk("rst_state", 128'(dbg16), 128'(ST_IDLE));
    RST = 1'b0;
    tick();

    // start without fresh randomness is ignored
    bus16.r_valid = 1'b0;
    bus16.start   = 1'b1;
    tick();
    bus16.start   = 1'b0;
    bus16.r_valid = 1'b1;
    chk("nostart_rvalid0", 128'(bus16.busy), 128'd0);

    // Mixed bytes including 00, 01, 02, 03, 53, FF
    x = 128'h00010203_53FF1020_304080AA_55C33C7E;
    run16("mixed", x, 128'h01234567_89ABCDEF_FEDCBA98_76543210);
    got = recomb16();
    chk("inv_00", 128'(got[8*15 +: 8]), 128'h00);
    chk("inv_01", 128'(got[8*14 +: 8]), 128'h01);
    chk("inv_02", 128'(got[8*13 +: 8]), 128'h8D);
    chk("inv_03", 128'(got[8*12 +: 8]), 128'hF6);
    chk("inv_53", 128'(got[8*11 +: 8]), 128'hCA);
    chk("inv_FF", 128'(got[8*10 +: 8]), 128'h1C);
    repeat (5) tick();
    chk("hold_idle", recomb16(), m_inv_state(x));

    // Random state with random masking
    x = rand128();
    run16("random", x, rand128());

    // All-zero then all-FF unmasked state
    run16("zeros", 128'd0, rand128());
    chk("zeros_const", recomb16(), 128'd0);
    run16("ones", {16{8'hFF}}, rand128());
    chk("ones_const", recomb16(), {16{8'h1C}});

    // Randomness underflow in ISSUE cycle 7
    x = 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;
    bus16.din1  = rand128();
    bus16.din0  = x ^ bus16.din1;
    bus16.start = 1'b1;
    tick();
    bus16.start = 1'b0;
    repeat (7) tick();
    chk("abort_pre_state", 128'(dbg16), 128'(ST_ISSUE));
    bus16.r_valid = 1'b0;
    tick();
    bus16.r_valid = 1'b1;
    chk("abort_err", 128'(bus16.err), 128'd1);
    chk("abort_busy", 128'(bus16.busy), 128'd0);
    chk("abort_done", 128'(bus16.done), 128'd0);
    seen = 0;
    repeat (30) begin
      tick();
      if (bus16.done) seen++;
    end
    chk("abort_no_done", 128'(seen), 128'd0);
    chk("abort_err_sticky", 128'(bus16.err), 128'd1);
    got = recomb16();
    x   = m_inv_state(x);
    chk("abort_bytes0_4", 128'(got[39:0]), 128'(x[39:0]));

    // Reset while byte 5 is being issued, then a clean run
    bus16.din1  = rand128();
    bus16.din0  = rand128();
    bus16.start = 1'b1;
    tick();
    bus16.start = 1'b0;
    repeat (5) tick();
    chk("midrst_pre_state", 128'(dbg16), 128'(ST_ISSUE));
    RST = 1'b1;
    #1;
    chk("midrst_busy", 128'(bus16.busy), 128'd0);
    chk("midrst_err", 128'(bus16.err), 128'd0);
    chk("midrst_dout", bus16.dout0 | bus16.dout1 | bus16.dout2 | bus16.dout3, 128'd0);
    tick();
    RST = 1'b0;
    tick();
    x = rand128();
    run16("after_rst", x, rand128());
    chk("after_rst_err", 128'(bus16.err), 128'd0);

    // start held for 40 cycles: back-to-back runs, 19-cycle done spacing
    x = rand128();
    bus16.din1  = rand128();
    bus16.din0  = x ^ bus16.din1;
    bus16.start = 1'b1;
    @(posedge CLK);
    seen   = 0;
    first  = -1;
    second = -1;
    for (int e = 0; e < 60; e++) begin
      @(negedge CLK);
      if (e == 39) bus16.start = 1'b0;
      if (bus16.done) begin
        seen++;
        if (first < 0) first = e;
        else if (second < 0) second = e;
      end
      @(posedge CLK);
    end
    @(negedge CLK);
    chk("b2b_first", 128'(first), 128'd18);
    chk("b2b_spacing", 128'(second - first), 128'd19);
    chk("b2b_count", 128'(seen), 128'd3);
    chk("b2b_data", recomb16(), m_inv_state(x));

    // Single-byte instance
    bus1.din1  = 8'hA7;
    bus1.din0  = 8'h53 ^ 8'hA7;
    bus1.start = 1'b1;
    tick();
    bus1.start = 1'b0;
    n = 0;
    while (!bus1.done && n < 20) begin
      tick();
      n++;
    end
    chk("nb1_latency", 128'(n), 128'd3);
    chk("nb1_inv53", 128'(bus1.dout0 ^ bus1.dout1 ^ bus1.dout2 ^ bus1.dout3), 128'hCA);
    tick();
    bus1.din1  = 8'h3C;
    bus1.din0  = 8'hFF ^ 8'h3C;
    bus1.start = 1'b1;
    tick();
    bus1.start = 1'b0;
    n = 0;
    while (!bus1.done && n < 20) begin
      tick();
      n++;
    end
    chk("nb1_latency2", 128'(n), 128'd3);
    chk("nb1_invFF", 128'(bus1.dout0 ^ bus1.dout1 ^ bus1.dout2 ^ bus1.dout3), 128'h1C);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/sbox_ti_sched.md
SBOX_TI_SCHED -- requirements
Module: sbox_ti_sched

Interface
REQ-001 SHALL have parameter NBYTES, default 16, number of state bytes sequenced per run (legal 1..16).
REQ-002 SHALL have port CLK  input  1  rising-edge clock.
REQ-003 SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start  input  1  request to process one state.
REQ-005 SHALL have ports din0, din1  input  8*NBYTES  2-share masked input state; byte k occupies bits [8k+7:8k].
REQ-006 SHALL have port r_in  input  28  fresh randomness for the inversion core.
REQ-007 SHALL have port r_valid  input  1  r_in is fresh this cycle.
REQ-008 SHALL have port r_ack  output  1  r_in consumed this cycle.
REQ-009 SHALL have port busy  output  1  run in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse: dout0..dout3 complete.
REQ-011 SHALL have port err  output  1  sticky randomness-underflow flag.
REQ-012 SHALL have ports dout0..dout3  output  8*NBYTES  4-share inverted state.

Function
REQ-013 SHALL implement FSM IDLE -> ISSUE -> DRAIN -> IDLE.
REQ-014 IDLE: start=1 and r_valid=1 at an edge SHALL latch din0/din1 into the input buffer, clear byte counter and err, enter ISSUE; start with r_valid=0 SHALL be ignored.
REQ-015 ISSUE: in the k-th cycle after entry (k=0..NBYTES-1), byte k of both shares SHALL drive the core; the last issue SHALL move the FSM to DRAIN.
REQ-016 DRAIN SHALL last exactly 2 cycles, then return to IDLE.
REQ-017 Core latency is 2 cycles; a 2-deep valid/index shift register SHALL track in-flight bytes, and the edge at which the valid tap is set SHALL write the core outputs into byte position k of dout0..dout3.
REQ-018 done SHALL be registered high for exactly the one cycle following the final capture edge; busy SHALL drop at that same edge (start-sample edge E0 -> done high after edge E0+NBYTES+2; NBYTES=16 gives 18 cycles).
REQ-019 r_in SHALL be forwarded to the core unregistered every cycle; r_ack SHALL equal busy.
REQ-020 r_valid=0 in any busy cycle SHALL set err, abort to IDLE at that edge, flush the valid pipe and suppress done; dout SHALL keep already-captured bytes.
REQ-021 start while busy SHALL be ignored.
REQ-022 dout0..dout3 SHALL hold their values from done until the next capture edge.

Reset
REQ-023 RST=1 SHALL immediately force IDLE, counter=0, valid pipe=0, busy=0, done=0, err=0, r_ack=0, dout0..dout3=0, input buffer=0, including mid-run.

Configuration
REQ-024 With macro SBOX_SCHED_GATE_EN defined, core data inputs SHALL be forced to 0 in every non-issue cycle.
REQ-025 Without SBOX_SCHED_GATE_EN, core data inputs SHALL hold the last issued byte in non-issue cycles; timing and outputs are otherwise identical.

Structure
REQ-026 The FSM state enum, the constant 28 (random width) and the core-latency constant 2 SHALL reside in the shared package sbox_ti_pkg.
REQ-027 SHALL instantiate exactly one sub-module, inversion_TI_opt, clocked by CLK; there SHALL be no other datapath sub-modules.

Verification
REQ-028 Reset mid-ISSUE (byte 5): RST pulse -> busy=0, dout=0, err=0 during reset; a fresh run then completes normally.
REQ-029 NBYTES=16, r_valid held 1, random din0/din1, start pulse -> done exactly 18 cycles after the start edge; dout0^dout1^dout2^dout3 byte k equals the GF(2^8) inverse of din0^din1 byte k (0 -> 0).
REQ-030 din0^din1=00..00, then all FF -> unmasked result 00 for every byte, then 1C for every byte.
REQ-031 r_valid dropped in ISSUE cycle 7 -> err=1 after that edge, done never pulses, busy=0 next cycle; dout bytes 0..4 hold valid results.
REQ-032 start held high for 40 cycles -> back-to-back runs, each done separated by 19 cycles; start during busy is not counted.
REQ-033 NBYTES=1 -> done 3 cycles after start; run under both SBOX_SCHED_GATE_EN settings gives identical dout.
